flag_producer: RTL

- Generates the 6-bit condition-flag word from ALU results in EX and delivers it to the flag management unit (FMU) write port at writeback.
- Drives the FMU `flags_in`/`write_enable` pair; the FMU is the reader and this block is the writer.
- Two-stage flag pipeline (S1 = MEM, S2 = WB) with stall and flush handling.
- Reports in-flight flag writes so decode can hold a jump-on-true/jump-on-false (jt/jf) until flags are committed.

---
 rtl/flag_producer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/flag_producer.sv
// flag_producer: builds the 6-bit condition-flag word from the EX-stage ALU
// result, then carries it through a two-entry pipeline (S1 = MEM, S2 = WB).
// It drives the FMU write port (flags_out / write_enable) at writeback, and it
// reports how many flag writes are in flight so decode can hold jt/jf.
module flag_producer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_set_flags,
  input  logic [1:0]            alu_op_class,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  carry_out,
  input  logic                  stall,
  input  logic                  flush,
  output logic [5:0]            flags_out,
  output logic                  write_enable,
  output logic [1:0]            flags_pending,
  output logic                  flags_busy
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [1:0] OP_LOGIC = 2'd0;
  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_SUB   = 2'd2;
  localparam logic [1:0] OP_SHIFT = 2'd3;

  // Flag word layout, matching FMU flag_code 0..5:
  // {overflow, negzero, carry, zero, neg, true}
  function automatic logic [5:0] compute_flags(
    input logic [1:0] op,
    input logic       a_msb,
    input logic       b_msb,
    input logic       r_msb,
    input logic       r_zero,
    input logic       cin
  );
    logic carry;
    logic ovf;
    case (op)
      OP_ADD: begin
        carry = cin;
        ovf   = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        // Carry is passed through as the ALU reports it; no borrow inversion.
        carry = cin;
        ovf   = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_SHIFT: begin
        carry = cin;
        ovf   = 1'b0;
      end
      OP_LOGIC: begin
        carry = 1'b0;
        ovf   = 1'b0;
      end
      default: begin
        carry = 1'b0;
        ovf   = 1'b0;
      end
    endcase
    return {ovf, r_msb | r_zero, carry, r_zero, r_msb, 1'b1};
  endfunction

  // Only the operand sign bits matter for the flags. The remaining operand
  // bits are deliberately left unused.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{operand_a[MSB-1:0], operand_b[MSB-1:0]};

  logic [5:0] ex_flags;
  logic       capture;

  logic       s1_valid;
  logic [5:0] s1_flags;
  logic       s2_valid;
  logic [5:0] s2_flags;

  // EX-stage flag word and the capture qualifier for S1
  always_comb begin
    ex_flags = compute_flags(alu_op_class, operand_a[MSB], operand_b[MSB],
                             alu_result[MSB], (alu_result == '0), carry_out);
    capture  = ex_valid & ex_set_flags & ~stall & ~flush;
  end

  // S1 (MEM): flush kills the entry, stall holds it, otherwise load from EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_flags <= 6'b000000;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s1_flags <= s1_flags;
    end else if (stall) begin
      s1_valid <= s1_valid;
      s1_flags <= s1_flags;
    end else begin
      s1_valid <= capture;
      s1_flags <= capture ? ex_flags : s1_flags;
    end
  end

  // S2 (WB): always drains after one write. It loads from S1 only when the
  // pipe advances, so flags_out keeps the last committed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_flags <= 6'b000000;
    end else if (stall || flush) begin
      s2_valid <= 1'b0;
      s2_flags <= s2_flags;
    end else begin
      s2_valid <= s1_valid;
      s2_flags <= s1_valid ? s1_flags : s2_flags;
    end
  end

  // Outputs come straight from stage registers, so they line up with stage contents
  assign flags_out     = s2_flags;
  assign write_enable  = s2_valid;
  assign flags_pending = {1'b0, s1_valid} + {1'b0, s2_valid};
  assign flags_busy    = s1_valid | s2_valid;

endmodule
